// File: rtl/dm_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_port_arbiter_if
//  Description : Bundle of the two requester ports (cpu_*, dbg_*) and the
//                single data-memory port (mem_*) shared by dm_port_arbiter.
//  Ports       : none (signal bundle only)
//                slave  modport - arbiter side: sees requests, drives
//                                 gnt/ack/err/rdata and the mem_* outputs
//                master modport - requester/memory side: the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_port_arbiter_if;
    // CPU (pipeline MEM stage) port
    logic        cpu_req;
    logic        cpu_wr;
    logic [5:0]  cpu_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    // Debug / program-loader port
    logic        dbg_req;
    logic        dbg_wr;
    logic [5:0]  dbg_op;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_ack;
    logic        dbg_err;
    logic [31:0] dbg_rdata;
    // Data-memory port
    logic        mem_wr;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_wr, cpu_op, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_ack, cpu_err, cpu_rdata,
        input  dbg_req, dbg_wr, dbg_op, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_ack, dbg_err, dbg_rdata,
        output mem_wr, mem_op, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_wr, cpu_op, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_ack, cpu_err, cpu_rdata,
        output dbg_req, dbg_wr, dbg_op, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_ack, dbg_err, dbg_rdata,
        input  mem_wr, mem_op, mem_addr, mem_din,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_port_arbiter
//  Description : Shares the single data memory between the CPU MEM stage and
//                the debug/program-loader port. One latched access per two
//                cycles (IDLE/RESP -> ACCESS -> RESP), registered gnt, ack,
//                err and read data per port.
//  Ports       : clk   - clock, all state updates on posedge
//                rst_n - asynchronous active-low reset
//                bus   - dm_port_arbiter_if.slave (cpu_*, dbg_*, mem_*)
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned CPU_PRIO = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_port_arbiter_if.slave  bus
);

    localparam logic [5:0] c_OP_LB  = 6'b100000;
    localparam logic [5:0] c_OP_LBU = 6'b100100;
    localparam logic [5:0] c_OP_SB  = 6'b101000;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_dbg_q;   // 1: dbg was served last
    logic [3:0]  wait_q;        // arbitrations lost by dbg since its last win
    logic        wr_q;
    logic        err_q;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        mem_wr_q;
    logic        cpu_gnt_q, cpu_ack_q, cpu_err_q;
    logic        dbg_gnt_q, dbg_ack_q, dbg_err_q;
    logic [31:0] cpu_rdata_q, dbg_rdata_q;

    logic        w_any_req;
    logic        w_dbg_tie;
    logic        w_win_dbg;
    logic        w_win_wr;
    logic [5:0]  w_win_op;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic        w_win_word;
    logic        w_win_err;
    logic [3:0]  wait_d;

    // Arbitration and error classification of the request about to be latched
    always_comb begin
        w_any_req = bus.cpu_req | bus.dbg_req;
        // Tie-break: fixed priority lets dbg through once the guard expires;
        // round-robin hands the tie to whoever was not served last.
        if (CPU_PRIO != 0) begin
            w_dbg_tie = (wait_q == c_MAX_WAIT);
        end else begin
            w_dbg_tie = ~owner_dbg_q;
        end
        w_win_dbg   = bus.dbg_req & (~bus.cpu_req | w_dbg_tie);
        w_win_wr    = w_win_dbg ? bus.dbg_wr    : bus.cpu_wr;
        w_win_op    = w_win_dbg ? bus.dbg_op    : bus.cpu_op;
        w_win_addr  = w_win_dbg ? bus.dbg_addr  : bus.cpu_addr;
        w_win_wdata = w_win_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        w_win_word  = (w_win_op != c_OP_LB) && (w_win_op != c_OP_LBU) &&
                      (w_win_op != c_OP_SB);
        // Shifting out the backed bits leaves only the out-of-range part
        w_win_err   = (w_win_word & (w_win_addr[1:0] != 2'b00)) |
                      ((w_win_addr >> ADDR_W) != 32'd0);
        wait_d = wait_q;
        if (w_win_dbg) begin
            wait_d = 4'd0;
        end else if (bus.dbg_req && (wait_q != c_MAX_WAIT)) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_dbg_q <= 1'b0;
            wait_q      <= 4'd0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= 6'd0;
            addr_q      <= 32'd0;
            din_q       <= 32'd0;
            mem_wr_q    <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            cpu_rdata_q <= 32'd0;
            dbg_rdata_q <= 32'd0;
        end else begin
            // gnt/ack/err/mem_wr are single-cycle pulses
            cpu_gnt_q <= 1'b0;
            dbg_gnt_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dbg_err_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (w_any_req) begin
                        state_q     <= ST_ACCESS;
                        owner_dbg_q <= w_win_dbg;
                        wait_q      <= wait_d;
                        wr_q        <= w_win_wr;
                        err_q       <= w_win_err;
                        op_q        <= w_win_op;
                        addr_q      <= w_win_addr;
                        din_q       <= w_win_wdata;
                        mem_wr_q    <= w_win_wr & ~w_win_err;
                        cpu_gnt_q   <= ~w_win_dbg;
                        dbg_gnt_q   <= w_win_dbg;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    if (owner_dbg_q) begin
                        dbg_ack_q   <= 1'b1;
                        dbg_err_q   <= err_q;
                        dbg_rdata_q <= (err_q | wr_q) ? 32'd0 : bus.mem_dout;
                    end else begin
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= err_q;
                        cpu_rdata_q <= (err_q | wr_q) ? 32'd0 : bus.mem_dout;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_gnt   = dbg_gnt_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_err   = dbg_err_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_op    = op_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_port_arbiter
//  Description : Directed self-checking bench for dm_port_arbiter. u_p1 uses
//                fixed CPU priority (MAX_WAIT=4) with a byte-addressed data
//                memory model; u_p0 uses round-robin for the grant-order test.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dm_port_arbiter_if bif ();
    dm_port_arbiter_if bif0 ();

    dm_port_arbiter #(.ADDR_W(12), .CPU_PRIO(1), .MAX_WAIT(4)) u_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    dm_port_arbiter #(.ADDR_W(12), .CPU_PRIO(0), .MAX_WAIT(4)) u_p0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif0)
    );

    assign bif0.mem_dout = 32'd0;

    // Data memory model: combinational read, write on negedge
    logic [7:0]  dm [0:4095];
    logic [11:0] dm_a;
    logic [11:0] dm_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) dm[i] <= 8'h00;
        end else if (bif.mem_wr) begin
            if (bif.mem_op == OP_SB) begin
                dm[bif.mem_addr[11:0]] <= bif.mem_din[7:0];
            end else begin
                dm[{bif.mem_addr[11:2], 2'b00}] <= bif.mem_din[7:0];
                dm[{bif.mem_addr[11:2], 2'b01}] <= bif.mem_din[15:8];
                dm[{bif.mem_addr[11:2], 2'b10}] <= bif.mem_din[23:16];
                dm[{bif.mem_addr[11:2], 2'b11}] <= bif.mem_din[31:24];
            end
        end
    end

    always_comb begin
        dm_a = bif.mem_addr[11:0];
        dm_w = {dm_a[11:2], 2'b00};
        case (bif.mem_op)
            OP_LB:   bif.mem_dout = {{24{dm[dm_a][7]}}, dm[dm_a]};
            OP_LBU:  bif.mem_dout = {24'd0, dm[dm_a]};
            default: bif.mem_dout = {dm[{dm_a[11:2], 2'b11}], dm[{dm_a[11:2], 2'b10}],
                                     dm[{dm_a[11:2], 2'b01}], dm[dm_w]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access on u_p1; called at a negedge, returns at the RESP negedge
    task automatic access(input bit is_dbg, input bit wr, input logic [5:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit e_err, input logic [31:0] e_rd, input string tag);
        if (is_dbg) begin
            bif.dbg_req = 1'b1; bif.dbg_wr = wr; bif.dbg_op = op;
            bif.dbg_addr = addr; bif.dbg_wdata = wd;
        end else begin
            bif.cpu_req = 1'b1; bif.cpu_wr = wr; bif.cpu_op = op;
            bif.cpu_addr = addr; bif.cpu_wdata = wd;
        end
        @(negedge clk);
        chk({tag, ".gnt"},       is_dbg ? bif.dbg_gnt : bif.cpu_gnt, 32'd1);
        chk({tag, ".other_gnt"}, is_dbg ? bif.cpu_gnt : bif.dbg_gnt, 32'd0);
        chk({tag, ".early_ack"}, is_dbg ? bif.dbg_ack : bif.cpu_ack, 32'd0);
        chk({tag, ".mem_wr"},    bif.mem_wr, {31'd0, wr & ~e_err});
        chk({tag, ".mem_addr"},  bif.mem_addr, addr);
        if (is_dbg) bif.dbg_req = 1'b0;
        else        bif.cpu_req = 1'b0;
        @(negedge clk);
        chk({tag, ".ack"},       is_dbg ? bif.dbg_ack : bif.cpu_ack, 32'd1);
        chk({tag, ".other_ack"}, is_dbg ? bif.cpu_ack : bif.dbg_ack, 32'd0);
        chk({tag, ".err"},       is_dbg ? bif.dbg_err : bif.cpu_err, {31'd0, e_err});
        chk({tag, ".rdata"},     is_dbg ? bif.dbg_rdata : bif.cpu_rdata, e_rd);
        chk({tag, ".resp_mem_wr"}, bif.mem_wr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.cpu_req = 0; bif.cpu_wr = 0; bif.cpu_op = 0; bif.cpu_addr = 0; bif.cpu_wdata = 0;
        bif.dbg_req = 0; bif.dbg_wr = 0; bif.dbg_op = 0; bif.dbg_addr = 0; bif.dbg_wdata = 0;
        bif0.cpu_req = 0; bif0.cpu_wr = 0; bif0.cpu_op = 0; bif0.cpu_addr = 0; bif0.cpu_wdata = 0;
        bif0.dbg_req = 0; bif0.dbg_wr = 0; bif0.dbg_op = 0; bif0.dbg_addr = 0; bif0.dbg_wdata = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst.pulses", {25'd0, bif.cpu_gnt, bif.dbg_gnt, bif.cpu_ack, bif.dbg_ack,
                           bif.cpu_err, bif.dbg_err, bif.mem_wr}, 32'd0);
        chk("rst.cpu_rdata", bif.cpu_rdata, 32'd0);
        chk("rst.dbg_rdata", bif.dbg_rdata, 32'd0);
        chk("rst.mem_addr",  bif.mem_addr, 32'd0);
        chk("rst.mem_din",   bif.mem_din, 32'd0);
        chk("rst.mem_op",    {26'd0, bif.mem_op}, 32'd0);

        // Reset in the middle of an access drops it
        @(negedge clk);
        bif.cpu_req = 1'b1; bif.cpu_wr = 1'b1; bif.cpu_op = OP_SW;
        bif.cpu_addr = 32'h40; bif.cpu_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        chk("midrst.gnt_before",    bif.cpu_gnt, 32'd1);
        chk("midrst.mem_wr_before", bif.mem_wr, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.mem_wr",   bif.mem_wr, 32'd0);
        chk("midrst.gnt",      bif.cpu_gnt, 32'd0);
        chk("midrst.mem_addr", bif.mem_addr, 32'd0);
        @(negedge clk);
        bif.cpu_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst.no_stale_ack", {29'd0, bif.cpu_ack, bif.cpu_gnt, bif.mem_wr}, 32'd0);
        end
        access(1'b0, 1'b0, OP_LW, 32'h40, 32'h0, 1'b0, 32'h0, "midrst.read_back");

        // CPU store then load
        access(1'b0, 1'b1, OP_SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "cpu_sw");
        access(1'b0, 1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "cpu_lw");
        access(1'b1, 1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "dbg_lw");
        chk("cpu_rdata_hold", bif.cpu_rdata, 32'hDEADBEEF);

        // Misaligned word accesses error out and never write
        access(1'b0, 1'b0, OP_LW, 32'h12, 32'h0, 1'b1, 32'h0, "cpu_lw_mis");
        access(1'b0, 1'b1, OP_SW, 32'h12, 32'hCAFEF00D, 1'b1, 32'h0, "cpu_sw_mis");
        access(1'b0, 1'b0, OP_LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "cpu_lw_after_mis");
        access(1'b0, 1'b1, OP_SB, 32'h13, 32'h000000A5, 1'b0, 32'h0, "cpu_sb_odd");
        access(1'b0, 1'b0, OP_LBU, 32'h13, 32'h0, 1'b0, 32'h000000A5, "cpu_lbu_odd");

        // Out-of-range accesses
        access(1'b1, 1'b1, OP_SW, 32'h1000, 32'h12345678, 1'b1, 32'h0, "dbg_sw_oor");
        access(1'b1, 1'b0, OP_LW, 32'h0, 32'h0, 1'b0, 32'h0, "dbg_lw_0");
        access(1'b0, 1'b0, OP_LBU, 32'h80000003, 32'h0, 1'b1, 32'h0, "cpu_lbu_oor");

        // Back-to-back: RESP goes straight to ACCESS
        access(1'b1, 1'b1, OP_SB, 32'h20, 32'h0000007F, 1'b0, 32'h0, "dbg_sb");
        access(1'b0, 1'b0, OP_LB, 32'h20, 32'h0, 1'b0, 32'h0000007F, "cpu_lb_b2b");

        // Both requesting continuously
        bif.cpu_req = 1'b1; bif.cpu_wr = 1'b0; bif.cpu_op = OP_LW; bif.cpu_addr = 32'h10;
        bif.dbg_req = 1'b1; bif.dbg_wr = 1'b0; bif.dbg_op = OP_LW; bif.dbg_addr = 32'h0;
        bif0.cpu_req = 1'b1; bif0.cpu_op = OP_LW; bif0.cpu_addr = 32'h10;
        bif0.dbg_req = 1'b1; bif0.dbg_op = OP_LW; bif0.dbg_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            logic e1;
            logic e0;
            e1 = (i == 4) || (i == 9);
            e0 = (i % 2) == 0;
            @(negedge clk);
            chk($sformatf("prio.gnt%0d", i), {30'd0, bif.dbg_gnt, bif.cpu_gnt}, {30'd0, e1, ~e1});
            chk($sformatf("rr.gnt%0d", i), {30'd0, bif0.dbg_gnt, bif0.cpu_gnt}, {30'd0, e0, ~e0});
            @(negedge clk);
            if (i == 9) begin
                bif.cpu_req = 1'b0;  bif.dbg_req = 1'b0;
                bif0.cpu_req = 1'b0; bif0.dbg_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("idle_after_contention", {30'd0, bif.cpu_gnt | bif.dbg_gnt, bif.mem_wr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
